// File: rtl/sub_seq_pkg.sv
// sub_seq_pkg: shared widths, state encoding and helpers for the multi-cycle subtractor.
package sub_seq_pkg;
    localparam int DEF_INPUTSIZE = 32;
    localparam int DEF_GROUPSIZE = 4;
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_NEG  = 2'd2,
        S_DONE = 2'd3
    } state_e;
    function automatic int cnt_width(input int ng);
        return (ng > 1) ? $clog2(ng) : 1;
    endfunction
endpackage

// File: rtl/sub_seq_group_sub.sv
// group_sub: combinational Groupsize-bit subtractor with borrow in/out.
module group_sub #(
    parameter int Groupsize = 4
) (
    input  logic [Groupsize-1:0] a_i,
    input  logic [Groupsize-1:0] b_i,
    input  logic                 bin_i,
    output logic [Groupsize-1:0] d_o,
    output logic                 bout_o
);
    // Wraparound in Groupsize+1 bits leaves the borrow in the MSB.
    assign {bout_o, d_o} = {1'b0, a_i} - {1'b0, b_i} - {{Groupsize{1'b0}}, bin_i};
endmodule

// File: rtl/sub_seq.sv
// sub_seq: group-serial unsigned a-b, one group per cycle LSB first, sign-magnitude result.
module sub_seq
    import sub_seq_pkg::*;
#(
    parameter int INPUTSIZE = DEF_INPUTSIZE,
    parameter int GROUPSIZE = DEF_GROUPSIZE
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 in_valid_i,
    output logic                 in_ready_o,
    input  logic [INPUTSIZE-1:0] a_i,
    input  logic [INPUTSIZE-1:0] b_i,
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output logic [INPUTSIZE:0]   result_o
);
    localparam int NG = INPUTSIZE / GROUPSIZE;
    localparam int CW = cnt_width(NG);

    if (INPUTSIZE % GROUPSIZE != 0) begin : g_bad_size
        $error("INPUTSIZE must be a multiple of GROUPSIZE");
    end

    state_e               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic                 borrow_q, borrow_d;
    logic [INPUTSIZE-1:0] diff_q, diff_d;
    logic [INPUTSIZE-1:0] a_q, a_d, b_q, b_d;
    logic [INPUTSIZE:0]   result_q, result_d;
    logic [GROUPSIZE-1:0] grp_d;
    logic                 grp_bout;

    group_sub #(.Groupsize(GROUPSIZE)) u_group_sub (
        .a_i    (a_q[cnt_q*GROUPSIZE +: GROUPSIZE]),
        .b_i    (b_q[cnt_q*GROUPSIZE +: GROUPSIZE]),
        .bin_i  (borrow_q),
        .d_o    (grp_d),
        .bout_o (grp_bout)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        borrow_d = borrow_q;
        diff_d   = diff_q;
        a_d      = a_q;
        b_d      = b_q;
        result_d = result_q;
        unique case (state_q)
            S_IDLE: if (in_valid_i) begin
                a_d      = a_i;
                b_d      = b_i;
                cnt_d    = '0;
                borrow_d = 1'b0;
                state_d  = S_CALC;
            end
            S_CALC: begin
                diff_d[cnt_q*GROUPSIZE +: GROUPSIZE] = grp_d;
                borrow_d = grp_bout;
                cnt_d    = cnt_q + 1'b1;
                state_d  = (cnt_q == CW'(NG-1)) ? S_NEG : S_CALC;
            end
            S_NEG: begin
                // A final borrow means a<b, so the magnitude is the two's complement of diff.
                result_d = borrow_q ? {1'b1, ~diff_q + INPUTSIZE'(1)} : {1'b0, diff_q};
                state_d  = S_DONE;
            end
            S_DONE: state_d = out_ready_i ? S_IDLE : S_DONE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            borrow_q <= 1'b0;
            diff_q   <= '0;
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            borrow_q <= borrow_d;
            diff_q   <= diff_d;
            a_q      <= a_d;
            b_q      <= b_d;
            result_q <= result_d;
        end
    end

    assign in_ready_o  = (state_q == S_IDLE);
    assign out_valid_o = (state_q == S_DONE);
    assign result_o    = result_q;
endmodule
